// File: rtl/bht_update_sched_pkg.sv
// Shared types, constants and the 2-bit saturating counter rule for the BHT update scheduler.
package bht_update_sched_pkg;

  localparam int unsigned DEFAULT_VLEN = 32;

  typedef struct packed {
    int unsigned VLEN;
    logic        RVC;
    int unsigned INSTR_PER_FETCH;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: DEFAULT_VLEN, RVC: 1'b1, INSTR_PER_FETCH: 2};

  typedef struct packed {
    logic                    valid;
    logic [DEFAULT_VLEN-1:0] pc;
    logic                    taken;
  } bht_update_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] saturation_counter;
  } bht_t;

  localparam bht_t BHT_FLUSH_ENTRY = '{valid: 1'b0, saturation_counter: 2'b10};

  typedef enum logic {
    FLUSH,
    RUN
  } state_e;

  function automatic bht_t bht_sat_update(bht_t old, logic taken);
    bht_t upd;
    upd.valid = 1'b1;
    if (old.saturation_counter == 2'b11 && taken) begin
      upd.saturation_counter = 2'b11;
    end else if (old.saturation_counter == 2'b00 && !taken) begin
      upd.saturation_counter = 2'b00;
    end else if (taken) begin
      upd.saturation_counter = old.saturation_counter + 2'b01;
    end else begin
      upd.saturation_counter = old.saturation_counter - 2'b01;
    end
    return upd;
  endfunction

endpackage

// File: rtl/bht_update_sched_if.sv
// Bundle of the update-side inputs and BHT RAM port signals; master is the scheduler, slave the environment.
interface bht_update_sched_if #(
  parameter int unsigned NR_ROWS = 512,
  parameter int unsigned IPF     = 2
);
  import bht_update_sched_pkg::*;

  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);

  logic                flush_bp_i;
  logic                debug_mode_i;
  bht_update_t         bht_update_i;
  logic [ROW_BITS-1:0] tbl_raddr_o;
  logic [IPF*3-1:0]    tbl_rdata_i;
  logic                tbl_we_o;
  logic [ROW_BITS-1:0] tbl_waddr_o;
  logic [IPF-1:0]      tbl_wbank_o;
  logic [2:0]          tbl_wdata_o;
  logic                flush_busy_o;
  logic                drop_o;

  modport master (
    input  flush_bp_i, debug_mode_i, bht_update_i, tbl_rdata_i,
    output tbl_raddr_o, tbl_we_o, tbl_waddr_o, tbl_wbank_o, tbl_wdata_o, flush_busy_o, drop_o
  );

  modport slave (
    output flush_bp_i, debug_mode_i, bht_update_i, tbl_rdata_i,
    input  tbl_raddr_o, tbl_we_o, tbl_waddr_o, tbl_wbank_o, tbl_wdata_o, flush_busy_o, drop_o
  );

endinterface

// File: rtl/bht_update_sched_fifo.sv
// Small synchronous FIFO holding pending branch updates; a push into a full queue is accepted
// when a pop happens in the same cycle.
module bht_update_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bht_update_sched.sv
// Single writer for the BHT RAM: row-by-row flush walk, then a 2-stage read-modify-write
// pipeline for queued branch updates with a 1-deep forward of the last written counter.
module bht_update_sched
  import bht_update_sched_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
  parameter int unsigned NR_ROWS     = 512,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  bht_update_sched_if.master bus
);
  localparam int unsigned IPF      = CVA6Cfg.INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned AB       = $clog2(IPF);
  localparam int unsigned OFFSET   = CVA6Cfg.RVC ? 1 : 2;
  localparam int unsigned BANK_W   = (AB > 0) ? AB : 1;
  localparam int unsigned ENTRY_W  = ROW_BITS + BANK_W + 1;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  typedef struct packed {
    logic [ROW_BITS-1:0] row;
    logic [BANK_W-1:0]   bank;
    logic                taken;
  } entry_t;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] walk_q, walk_d;
  logic                s1_valid_q, s1_valid_d;
  entry_t              s1_q, s1_d;
  logic                fwd_valid_q, fwd_valid_d;
  logic [ROW_BITS-1:0] fwd_row_q, fwd_row_d;
  logic [BANK_W-1:0]   fwd_bank_q, fwd_bank_d;
  logic [1:0]          fwd_ctr_q, fwd_ctr_d;
  logic                drop_q, drop_d;

  entry_t              push_entry, head;
  logic                push, pop, full, empty, push_req, run, we, unused_pc;
  logic [ROW_BITS-1:0] waddr;
  logic [IPF-1:0]      wbank;
  bht_t                wdata, old_entry, new_entry;

  assign unused_pc = ^bus.bht_update_i.pc;

  always_comb begin
    push_entry.row   = bus.bht_update_i.pc[AB+OFFSET +: ROW_BITS];
    push_entry.bank  = '0;
    push_entry.taken = bus.bht_update_i.taken;
    if (CVA6Cfg.RVC && AB > 0) begin
      push_entry.bank = bus.bht_update_i.pc[OFFSET +: BANK_W];
    end
  end

  bht_update_fifo #(
    .DEPTH(QUEUE_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(bus.flush_bp_i),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d     = state_q;
    walk_d      = walk_q;
    s1_valid_d  = 1'b0;
    s1_d        = head;
    fwd_valid_d = 1'b0;
    fwd_row_d   = s1_q.row;
    fwd_bank_d  = s1_q.bank;
    fwd_ctr_d   = fwd_ctr_q;
    we          = 1'b0;
    waddr       = walk_q;
    wbank       = '0;
    wdata       = BHT_FLUSH_ENTRY;
    old_entry   = bus.tbl_rdata_i[3*s1_q.bank +: 3];
    new_entry   = old_entry;
    run         = (state_q == RUN);
    pop         = run && !empty && !bus.flush_bp_i;
    push_req    = bus.bht_update_i.valid && !bus.debug_mode_i && !bus.flush_bp_i;
    push        = push_req && (!full || pop);
    drop_d      = push_req && full && !pop;

    if (!run) begin
      we     = 1'b1;
      wbank  = '1;
      walk_d = walk_q + ROW_ONE;
      if (walk_q == LAST_ROW) begin
        state_d = RUN;
      end
    end else if (s1_valid_q) begin
      // RAM returns pre-write data, so a back-to-back hit must take last cycle's result
      if (fwd_valid_q && fwd_row_q == s1_q.row && fwd_bank_q == s1_q.bank) begin
        old_entry.saturation_counter = fwd_ctr_q;
      end
      new_entry          = bht_sat_update(old_entry, s1_q.taken);
      we                 = 1'b1;
      waddr              = s1_q.row;
      wbank[s1_q.bank]   = 1'b1;
      wdata              = new_entry;
      fwd_valid_d        = 1'b1;
      fwd_ctr_d          = new_entry.saturation_counter;
    end
    s1_valid_d = pop;

    if (bus.flush_bp_i) begin
      state_d     = FLUSH;
      walk_d      = '0;
      s1_valid_d  = 1'b0;
      fwd_valid_d = 1'b0;
      if (run) begin
        we = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FLUSH;
      walk_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      fwd_valid_q <= 1'b0;
      fwd_row_q   <= '0;
      fwd_bank_q  <= '0;
      fwd_ctr_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      walk_q      <= walk_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_row_q   <= fwd_row_d;
      fwd_bank_q  <= fwd_bank_d;
      fwd_ctr_q   <= fwd_ctr_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.tbl_raddr_o  = head.row;
  assign bus.tbl_we_o     = we && !rst_i;
  assign bus.tbl_waddr_o  = waddr;
  assign bus.tbl_wbank_o  = wbank;
  assign bus.tbl_wdata_o  = wdata;
  assign bus.flush_busy_o = rst_i || (state_q != RUN);
  assign bus.drop_o       = drop_q && !rst_i;

endmodule

// File: tb/tb_bht_update_sched.sv
// Scoreboard bench for bht_update_sched: a RAM model behind the write/read ports, a per-entry counter
// model updated in program order, and a monitor that checks every write, flush row and drop pulse.
module tb_bht_update_sched;
  import bht_update_sched_pkg::*;

  localparam int NR_ROWS = 8;
  localparam int IPF     = 2;
  localparam int QD      = 4;
  localparam cva6_cfg_t CFG = '{VLEN: 32, RVC: 1'b1, INSTR_PER_FETCH: 2};

  typedef struct {
    int unsigned pc;
    bit          taken;
    int          issue;
    bit          chk_lat;
  } upd_s;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bht_update_sched_if #(.NR_ROWS(NR_ROWS), .IPF(IPF)) bus ();

  bht_update_sched #(
    .CVA6Cfg    (CFG),
    .NR_ROWS    (NR_ROWS),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  upd_s pending[$];
  int   ctr_model [NR_ROWS][IPF];
  int   cycle = 0;
  bit   in_flush = 1'b1;
  int   exp_walk = 0;
  bit   drop_now = 1'b0;
  bit   drop_prev = 1'b0;
  int   checks = 0;
  int   passes = 0;

  // RAM with a registered read port that returns the old contents on a same-row write
  logic [2:0] ram [NR_ROWS][IPF];
  always @(posedge clk) begin
    for (int b = 0; b < IPF; b++) begin
      bus.tbl_rdata_i[3*b +: 3] <= ram[bus.tbl_raddr_o][b];
      if (bus.tbl_we_o && bus.tbl_wbank_o[b]) ram[bus.tbl_waddr_o][b] <= bus.tbl_wdata_o;
    end
  end

  always @(posedge clk) cycle++;

  function automatic int row_of(int unsigned pc);
    return int'((pc >> 2) % NR_ROWS);
  endfunction

  function automatic int bank_of(int unsigned pc);
    return int'((pc >> 1) % IPF);
  endfunction

  function automatic int sat(int c, bit taken);
    if (taken) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int unsigned mk_pc(int row, int bank);
    return int'(row * 4 + bank * 2);
  endfunction

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h cycle=%0d", name, actual, expected, cycle);
  endtask

  task automatic resetModel();
    pending.delete();
    foreach (ctr_model[i, j]) ctr_model[i][j] = 2;
  endtask

  // Drives one cycle of inputs and records the expected outcome (queued update or drop)
  task automatic applyStimulus(input bit v, input int unsigned pc, input bit tk, input bit fl,
                               input bit dbg, input bit lat);
    @(posedge clk);
    #1;
    bus.bht_update_i = '{valid: v, pc: pc, taken: tk};
    bus.flush_bp_i   = fl;
    bus.debug_mode_i = dbg;
    if (fl) begin
      resetModel();
    end else if (v && !dbg) begin
      if (in_flush && pending.size() >= QD) drop_now = 1'b1;
      else pending.push_back('{pc: pc, taken: tk, issue: cycle, chk_lat: lat});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: walks the expected flush rows and pops the scoreboard on every update write
  always @(negedge clk) begin
    upd_s u;
    int   r, b, nc;
    if (rst) begin
      checkOutput("rst_we", bus.tbl_we_o, 0);
      checkOutput("rst_busy", bus.flush_busy_o, 1);
      checkOutput("rst_drop", bus.drop_o, 0);
      in_flush  = 1'b1;
      exp_walk  = 0;
      drop_prev = 1'b0;
      drop_now  = 1'b0;
    end else begin
      checkOutput("drop", bus.drop_o, drop_prev);
      drop_prev = drop_now;
      drop_now  = 1'b0;
      if (in_flush) begin
        checkOutput("walk_busy", bus.flush_busy_o, 1);
        checkOutput("walk_we", bus.tbl_we_o, 1);
        checkOutput("walk_row", bus.tbl_waddr_o, exp_walk);
        checkOutput("walk_bank", bus.tbl_wbank_o, 3);
        checkOutput("walk_data", bus.tbl_wdata_o, 3'b010);
        if (bus.flush_bp_i) exp_walk = 0;
        else if (exp_walk == NR_ROWS - 1) begin
          in_flush = 1'b0;
          exp_walk = 0;
        end else exp_walk++;
      end else begin
        checkOutput("run_busy", bus.flush_busy_o, 0);
        if (bus.flush_bp_i) begin
          checkOutput("flush_we", bus.tbl_we_o, 0);
          in_flush = 1'b1;
          exp_walk = 0;
        end else if (bus.tbl_we_o) begin
          if (pending.size() == 0) begin
            checkOutput("spurious_write", pending.size(), 1);
          end else begin
            u  = pending.pop_front();
            r  = row_of(u.pc);
            b  = bank_of(u.pc);
            nc = sat(ctr_model[r][b], u.taken);
            ctr_model[r][b] = nc;
            checkOutput("upd_waddr", bus.tbl_waddr_o, r);
            checkOutput("upd_wbank", bus.tbl_wbank_o, 1 << b);
            checkOutput("upd_wdata", bus.tbl_wdata_o, 4 + nc);
            if (u.chk_lat) checkOutput("upd_latency", cycle - u.issue, 2);
          end
        end
      end
    end
  end

  initial begin
    bus.bht_update_i = '0;
    bus.flush_bp_i   = 1'b0;
    bus.debug_mode_i = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    idle(NR_ROWS + 2);
    $display("[TB] single taken update after initial walk");
    applyStimulus(1'b1, mk_pc(3, 1), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);

    $display("[TB] back-to-back updates through the forward path");
    applyStimulus(1'b1, mk_pc(5, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    repeat (3) applyStimulus(1'b1, mk_pc(5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    $display("[TB] queue overflow while walking");
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk_pc(i, i % 2), i[0], 1'b0, 1'b0, 1'b0);
    idle(NR_ROWS + 4);

    $display("[TB] flush restart mid-walk with a colliding update");
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    applyStimulus(1'b1, mk_pc(2, 0), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(NR_ROWS + 3);

    $display("[TB] debug mode and not-taken saturation");
    repeat (3) applyStimulus(1'b1, mk_pc(4, 1), 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    repeat (3) applyStimulus(1'b1, mk_pc(6, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, 1'b0);
    end
    idle(NR_ROWS + 10);
    checkOutput("drained", pending.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
